// File: rtl/axi_rd_xbar.sv
// axi_rd_xbar: single-outstanding AXI read crossbar, one master to SRAM (slave 0) and CLINT (slave 1)
module axi_rd_xbar #(
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter logic [31:0] S0_BASE = 32'h8000_0000,
    parameter logic [31:0] S0_MASK = 32'hF800_0000,
    parameter logic [31:0] S1_BASE = 32'h0200_0000,
    parameter logic [31:0] S1_MASK = 32'hFFFF_0000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                m_ar_valid_i,
    input  logic [ADDR_W-1:0]   m_ar_addr_i,
    output logic                m_ar_ready_o,
    output logic                m_r_valid_o,
    output logic [DATA_W-1:0]   m_r_data_o,
    output logic [1:0]          m_r_resp_o,
    input  logic                m_r_ready_i,
    output logic [1:0]          s_ar_valid_o,
    output logic [ADDR_W-1:0]   s_ar_addr_o,
    input  logic [1:0]          s_ar_ready_i,
    input  logic [1:0]          s_r_valid_i,
    input  logic [2*DATA_W-1:0] s_r_data_i,
    input  logic [3:0]          s_r_resp_i,
    output logic [1:0]          s_r_ready_o,
    output logic [7:0]          dec_err_cnt_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, DEC_ERR} state_t;
    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic              sel_q;
    logic              hit0, hit1, ar_hs;
    assign hit0  = (m_ar_addr_i & ADDR_W'(S0_MASK)) == ADDR_W'(S0_BASE);
    assign hit1  = (m_ar_addr_i & ADDR_W'(S1_MASK)) == ADDR_W'(S1_BASE);
    assign ar_hs = m_ar_valid_i && m_ar_ready_o;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= IDLE;
            addr_q        <= '0;
            sel_q         <= 1'b0;
            dec_err_cnt_o <= 8'd0;
        end else begin
            state <= state_n;
            if (ar_hs) begin
                addr_q <= m_ar_addr_i;
                sel_q  <= !hit0 && hit1;
            end
            if (state == DEC_ERR && m_r_ready_i && dec_err_cnt_o != 8'hFF)
                dec_err_cnt_o <= dec_err_cnt_o + 8'd1;
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = !ar_hs ? IDLE : hit0 || hit1 ? ISSUE : DEC_ERR;
            ISSUE:   state_n = s_ar_ready_i[sel_q] ? WAIT_R : ISSUE;
            WAIT_R:  state_n = s_r_valid_i[sel_q] && m_r_ready_i ? IDLE : WAIT_R;
            DEC_ERR: state_n = m_r_ready_i ? IDLE : DEC_ERR;
            default: state_n = IDLE;
        endcase
    end
    assign m_ar_ready_o = rst_i && state == IDLE;
    assign s_ar_addr_o  = addr_q;
    assign s_ar_valid_o = state == ISSUE ? {sel_q, !sel_q} : 2'b00;
    assign s_r_ready_o  = state == WAIT_R ? {sel_q && m_r_ready_i, !sel_q && m_r_ready_i} : 2'b00;
    assign m_r_valid_o  = state == WAIT_R ? s_r_valid_i[sel_q] : state == DEC_ERR;
    assign m_r_data_o   = state != WAIT_R ? '0 :
                          sel_q ? s_r_data_i[2*DATA_W-1:DATA_W] : s_r_data_i[DATA_W-1:0];
    assign m_r_resp_o   = state == DEC_ERR ? 2'b11 : state != WAIT_R ? 2'b00 :
                          sel_q ? s_r_resp_i[3:2] : s_r_resp_i[1:0];
endmodule

// File: tb/tb_axi_rd_xbar.sv
// tb_axi_rd_xbar: randomized transaction-level bench for axi_rd_xbar
module tb_axi_rd_xbar;
    logic        clk_i = 1'b0, rst_i = 1'b0;
    logic        m_ar_valid_i = 1'b0, m_r_ready_i = 1'b0;
    logic [31:0] m_ar_addr_i = '0;
    logic        m_ar_ready_o, m_r_valid_o;
    logic [31:0] m_r_data_o;
    logic [1:0]  m_r_resp_o;
    logic [1:0]  s_ar_valid_o, s_r_ready_o;
    logic [31:0] s_ar_addr_o;
    logic [1:0]  s_ar_ready_i = '0, s_r_valid_i = '0;
    logic [63:0] s_r_data_i = '0;
    logic [3:0]  s_r_resp_i = '0;
    logic [7:0]  dec_err_cnt_o;
    int          checks = 0, errors = 0;
    logic [7:0]  cnt_m = 8'd0;

    axi_rd_xbar dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_ar_valid_i(m_ar_valid_i), .m_ar_addr_i(m_ar_addr_i), .m_ar_ready_o(m_ar_ready_o),
        .m_r_valid_o(m_r_valid_o), .m_r_data_o(m_r_data_o), .m_r_resp_o(m_r_resp_o),
        .m_r_ready_i(m_r_ready_i),
        .s_ar_valid_o(s_ar_valid_o), .s_ar_addr_o(s_ar_addr_o), .s_ar_ready_i(s_ar_ready_i),
        .s_r_valid_i(s_r_valid_i), .s_r_data_i(s_r_data_i), .s_r_resp_i(s_r_resp_i),
        .s_r_ready_o(s_r_ready_o), .dec_err_cnt_o(dec_err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(negedge clk_i);
    endtask

    function automatic int route(input logic [31:0] a);
        if ((a & 32'hF800_0000) == 32'h8000_0000) return 0;
        if ((a & 32'hFFFF_0000) == 32'h0200_0000) return 1;
        return 2;
    endfunction

    task automatic do_read(input logic [31:0] addr, input int ar_stall, input int r_delay,
                           input int r_bp, input logic stray, input logic [31:0] data,
                           input logic [1:0] resp);
        int          sel, hs_m, hs_s;
        logic [1:0]  mine, oth;
        logic        sv, mr;
        logic [31:0] d [2];
        logic [1:0]  r [2];
        sel  = route(addr);
        hs_m = 0;
        hs_s = 0;
        mine = sel == 1 ? 2'b10 : 2'b01;
        oth  = ~mine;
        check("dec_cnt", dec_err_cnt_o, cnt_m);
        m_ar_valid_i = 1'b1;
        m_ar_addr_i  = addr;
        #1;
        check("ar_ready_idle", m_ar_ready_o, 1);
        check("no_comb_sar", s_ar_valid_o, 0);
        check("r_idle", {m_r_valid_o, m_r_resp_o, m_r_data_o}, 0);
        next();
        m_ar_valid_i = 1'b0;
        m_ar_addr_i  = $urandom;
        if (sel == 2) begin
            for (int i = 0; i <= r_bp; i++) begin
                m_r_ready_i = i == r_bp;
                #1;
                check("err_valid", m_r_valid_o, 1);
                check("err_resp", m_r_resp_o, 2'b11);
                check("err_data", m_r_data_o, 0);
                check("err_no_sar", s_ar_valid_o, 0);
                check("err_ar_ready", m_ar_ready_o, 0);
                next();
            end
            m_r_ready_i = 1'b0;
            if (cnt_m != 8'hFF) cnt_m++;
            return;
        end
        for (int i = 0; i <= ar_stall; i++) begin
            s_ar_ready_i = (i == ar_stall ? mine : 2'b00) | ($urandom_range(1) != 0 ? oth : 2'b00);
            #1;
            check("sar_valid", s_ar_valid_o, mine);
            check("sar_addr", s_ar_addr_o, addr);
            check("ar_ready_busy", m_ar_ready_o, 0);
            check("r_quiet_issue", m_r_valid_o, 0);
            next();
        end
        s_ar_ready_i = 2'b00;
        for (int i = 0; i < r_delay + r_bp + 1; i++) begin
            sv = i >= r_delay;
            mr = i == r_delay + r_bp ? 1'b1 : i < r_delay ? 1'($urandom_range(1)) : 1'b0;
            d[0] = $urandom; d[1] = $urandom;
            r[0] = 2'($urandom); r[1] = 2'($urandom);
            if (sv) begin
                d[sel] = data;
                r[sel] = resp;
            end
            s_r_valid_i = (sv ? mine : 2'b00) | (stray ? oth : 2'b00);
            s_r_data_i  = {d[1], d[0]};
            s_r_resp_i  = {r[1], r[0]};
            m_r_ready_i = mr;
            #1;
            check("r_valid", m_r_valid_o, sv);
            if (sv) begin
                check("r_data", m_r_data_o, data);
                check("r_resp", m_r_resp_o, resp);
            end
            check("s_r_ready", s_r_ready_o, mr ? mine : 2'b00);
            check("sar_idle_wait", s_ar_valid_o, 0);
            check("ar_ready_wait", m_ar_ready_o, 0);
            hs_m += int'(m_r_valid_o && m_r_ready_i);
            hs_s += int'(s_r_valid_i[sel] && s_r_ready_o[sel]);
            next();
        end
        s_r_valid_i = 2'b00;
        m_r_ready_i = 1'b0;
        check("hs_master", hs_m, 1);
        check("hs_slave", hs_s, 1);
    endtask

    initial begin
        logic [31:0] a;
        next();
        check("rst_ar_ready", m_ar_ready_o, 0);
        check("rst_cnt", dec_err_cnt_o, 0);
        check("rst_outs", {m_r_valid_o, m_r_data_o, m_r_resp_o, s_ar_valid_o, s_r_ready_o}, 0);
        check("rst_addr", s_ar_addr_o, 0);
        rst_i = 1'b1;
        next();
        do_read(32'h8000_0100, 0, 2, 0, 1'b0, 32'hDEAD_BEEF, 2'b00);
        do_read(32'h0200_BFF8, 3, 1, 0, 1'b0, 32'h1234_5678, 2'b00);
        do_read(32'h1000_0000, 0, 0, 0, 1'b0, 32'h0, 2'b00);
        do_read(32'h8000_0200, 0, 0, 4, 1'b0, 32'hCAFE_F00D, 2'b10);
        do_read(32'h8000_0300, 0, 2, 1, 1'b1, 32'h0BAD_F00D, 2'b00);
        do_read(32'h87FF_FFFC, 1, 0, 0, 1'b1, 32'hA5A5_5A5A, 2'b10);
        do_read(32'h8800_0000, 0, 0, 2, 1'b0, 32'h0, 2'b00);
        do_read(32'h0201_0000, 0, 0, 0, 1'b0, 32'h0, 2'b00);
        do_read(32'h0200_FFFF, 0, 0, 0, 1'b1, 32'hFFFF_FFFF, 2'b10);
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(2))
                0:       a = 32'h8000_0000 | ($urandom & 32'h07FF_FFFF);
                1:       a = 32'h0200_0000 | ($urandom & 32'h0000_FFFF);
                default: a = $urandom;
            endcase
            do_read(a, $urandom_range(3), $urandom_range(3), $urandom_range(3),
                    1'($urandom_range(1)), $urandom, 2'($urandom_range(1) * 2));
        end
        for (int n = 0; n < 260; n++)
            do_read(32'h4000_0000 | ($urandom & 32'h0FFF_FFFF), 0, 0, $urandom_range(1), 1'b0, 32'h0, 2'b00);
        check("cnt_saturated", dec_err_cnt_o, 8'hFF);
        m_ar_valid_i = 1'b1;
        m_ar_addr_i  = 32'h8000_0040;
        next();
        m_ar_valid_i = 1'b0;
        s_ar_ready_i = 2'b01;
        next();
        s_ar_ready_i = 2'b00;
        s_r_valid_i  = 2'b01;
        s_r_data_i   = {32'h0, 32'h5555_AAAA};
        #1;
        check("pre_rst_valid", m_r_valid_o, 1);
        #2;
        rst_i = 1'b0;
        #1;
        check("arst_outs", {m_ar_ready_o, m_r_valid_o, m_r_data_o, m_r_resp_o, s_ar_valid_o, s_r_ready_o}, 0);
        check("arst_cnt", dec_err_cnt_o, 0);
        check("arst_addr", s_ar_addr_o, 0);
        cnt_m = 8'd0;
        next();
        s_r_valid_i = 2'b00;
        rst_i = 1'b1;
        next();
        check("post_rst_ar_ready", m_ar_ready_o, 1);
        check("post_rst_r_valid", m_r_valid_o, 0);
        do_read(32'h1000_0000, 0, 0, 0, 1'b0, 32'h0, 2'b00);
        check("cnt_after_rst", dec_err_cnt_o, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_rd_xbar.md
Name: axi_rd_xbar

Overview:
- Single-outstanding AXI read crossbar: one upstream read master to two downstream read slaves.
- Upstream master is the output of the IFU/LSU read arbiter. Slave 0 is the main memory (SRAM); slave 1 is the CLINT.
- Decodes the AR address, forwards the request to exactly one slave and returns that slave's R beat upstream.
- Unmapped addresses get a locally generated DECERR response.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, read data width
- S0_BASE, 32'h8000_0000, slave 0 base address
- S0_MASK, 32'hF800_0000, slave 0 match mask (128 MiB window)
- S1_BASE, 32'h0200_0000, slave 1 base address
- S1_MASK, 32'hFFFF_0000, slave 1 match mask (64 KiB window)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- m_ar_valid_i  in  1  upstream AR valid
- m_ar_addr_i  in  ADDR_W  upstream AR address
- m_ar_ready_o  out  1  upstream AR ready
- m_r_valid_o  out  1  upstream R valid
- m_r_data_o  out  DATA_W  upstream R data
- m_r_resp_o  out  2  upstream R resp
- m_r_ready_i  in  1  upstream R ready
- s_ar_valid_o  out  2  per-slave AR valid; bit k = slave k
- s_ar_addr_o  out  ADDR_W  AR address, shared by both slaves
- s_ar_ready_i  in  2  per-slave AR ready
- s_r_valid_i  in  2  per-slave R valid
- s_r_data_i  in  2*DATA_W  R data; slave k in bits [k*DATA_W +: DATA_W]
- s_r_resp_i  in  2*2  R resp; slave k in bits [2k +: 2]
- s_r_ready_o  out  2  per-slave R ready
- dec_err_cnt_o  out  8  saturating count of DECERR responses issued

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE, addr_q=0, sel_q=0, dec_err_cnt_o=0.
  - All valid/ready outputs 0 while reset is asserted; m_ar_ready_o is gated low.
  - m_r_data_o=0, m_r_resp_o=0.
- Decode (combinational on m_ar_addr_i):
  - hit0 = (addr & S0_MASK) == S0_BASE; hit1 likewise with S1_MASK/S1_BASE.
  - hit0 has priority when both match.
- State IDLE:
  - m_ar_ready_o=1.
  - On m_ar_valid_i: latch addr_q and sel_q. hit0 -> ISSUE (sel 0); hit1 -> ISSUE (sel 1); neither -> DEC_ERR.
- State ISSUE:
  - s_ar_valid_o[sel_q]=1, s_ar_addr_o=addr_q, m_ar_ready_o=0.
  - Valid is held until s_ar_ready_i[sel_q]. On that handshake -> WAIT_R.
  - Earliest slave AR valid is the cycle after the upstream AR handshake.
- State WAIT_R (pass-through):
  - m_r_valid_o = s_r_valid_i[sel_q]; data and resp muxed from slave sel_q.
  - s_r_ready_o[sel_q] = m_r_ready_i.
  - On the R handshake -> IDLE, so a new AR can be accepted on the next cycle.
- State DEC_ERR:
  - m_r_valid_o=1, m_r_data_o=0, m_r_resp_o=2'b11.
  - On m_r_ready_i: -> IDLE and dec_err_cnt_o += 1, saturating at 8'hFF.
- Only one transaction is outstanding. m_ar_ready_o=0 in every state except IDLE.
- Non-selected slave:
  - s_ar_valid_o and s_r_ready_o bits stay 0.
  - Its s_r_valid_i is ignored and never reaches m_r_valid_o.
- Outside WAIT_R and DEC_ERR: m_r_valid_o=0, m_r_data_o=0, m_r_resp_o=0.
- s_ar_addr_o always equals addr_q; only the valid bits qualify it.
- Slave resp values (OKAY/SLVERR) are forwarded unmodified.
- Reset mid-transaction: the transaction is abandoned. No draining is done; slaves share the same reset.
- No combinational path from m_ar_valid_i to any s_* output.
- No timeout: a stalled slave holds the block in ISSUE or WAIT_R indefinitely.

Test Plan:
- Read to slave 0: addr 32'h8000_0100, s_ar_ready_i[0] high, slave returns data 32'hDEAD_BEEF with resp 0 two cycles later. Required: s_ar_valid_o=2'b01 the cycle after the AR handshake, s_ar_addr_o=32'h8000_0100, m_r_data_o=32'hDEAD_BEEF, m_r_resp_o=0, s_ar_valid_o[1] never 1.
- Read to slave 1: addr 32'h0200_BFF8, s_ar_ready_i[1] low for 3 cycles. Required: s_ar_valid_o[1] held high for all 3 stall cycles; m_ar_ready_o=0 throughout; data then returned from slave 1.
- Unmapped read: addr 32'h1000_0000. Required: no s_ar_valid_o bit ever set; m_r_valid_o=1 with resp 2'b11 and data 0 the cycle after the AR handshake; dec_err_cnt_o goes 0->1 after m_r_ready_i.
- R backpressure: m_r_ready_i held low 4 cycles while slave 0 holds r_valid. Required: s_r_ready_o[0]=0 for those cycles; data stable; exactly one R handshake on each side.
- Stray response: slave 1 asserts r_valid during a slave-0 transaction. Required: m_r_valid_o follows slave 0 only; s_r_ready_o[1]=0.
- Saturation and reset: 260 unmapped reads. Required: dec_err_cnt_o stops at 8'hFF. Then assert rst_i=0 asynchronously while in WAIT_R: all outputs 0 immediately, state IDLE, counter 0; after release, m_ar_ready_o=1 on the next cycle.
